mult_arbiter: RTL and testbench

- Shares one shift-and-add multiplier instance (START/A/B in, S/END_MULT out) between N_REQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the multiplier's START pulse, waits for completion, and returns the product to the winner with a one-cycle DONE strobe.
- Includes a watchdog that aborts a hung operation with an error flag.
- Sits between requesting units and the multiplier top level, on the same clock and reset.

---
 rtl/mult_arbiter.sv | 159 +++++++++++++++
 tb/tb_mult_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one shift-and-add multiplier among N_REQ requesters.
// GNT to DONE takes multiplier latency + 3 cycles; requests are only arbitrated while IDLE.
module mult_arbiter #(
  parameter int tamano  = 8,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ*tamano-1:0] A_IN,
  input  logic [N_REQ*tamano-1:0] B_IN,
  output logic [N_REQ-1:0]        GNT,
  output logic [N_REQ-1:0]        DONE,
  output logic [2*tamano-1:0]     RESULT,
  output logic                    ERR,
  output logic                    BUSY,
  output logic                    MULT_START,
  output logic [tamano-1:0]       MULT_A,
  output logic [tamano-1:0]       MULT_B,
  input  logic [2*tamano-1:0]     MULT_S,
  input  logic                    MULT_END
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW1 = PW + 1;
  localparam int WW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         win_q, win_d;
  logic [tamano-1:0]     a_q, a_d;
  logic [tamano-1:0]     b_q, b_d;
  logic [2*tamano-1:0]   result_q, result_d;
  logic                  err_q, err_d;
  logic [WW-1:0]         wd_q, wd_d;
  logic                  seen_low_q, seen_low_d;

  logic                  pick_vld;
  logic [PW-1:0]         pick_idx;

  // First requester at or above the pointer, wrapping explicitly for non-power-of-2 N_REQ.
  always_comb begin
    logic [PW1-1:0] sum;
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + PW1'(k);
      if (sum >= PW1'(N_REQ)) begin
        sum = sum - PW1'(N_REQ);
      end
      if (!pick_vld && REQ[sum[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    err_d      = err_q;
    wd_d       = wd_q;
    seen_low_d = seen_low_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          a_d     = A_IN[pick_idx*tamano +: tamano];
          b_d     = B_IN[pick_idx*tamano +: tamano];
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d       = '0;
        seen_low_d = 1'b0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WW'(1);
        if (!MULT_END) begin
          seen_low_d = 1'b1;
        end
        // A high END only counts once it has been seen low since launch.
        if (MULT_END && seen_low_q) begin
          result_d = MULT_S;
          err_d    = 1'b0;
          state_d  = S_RESPOND;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_RESPOND;
        end
      end
      S_RESPOND: begin
        err_d   = 1'b0;
        ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      wd_q       <= '0;
      seen_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
      seen_low_q <= seen_low_d;
    end
  end

  // GNT is gated by RESET so it drops at once when reset is asserted.
  always_comb begin
    GNT  = '0;
    DONE = '0;
    if (RESET && state_q == S_IDLE && pick_vld) begin
      GNT[pick_idx] = 1'b1;
    end
    if (state_q == S_RESPOND) begin
      DONE[win_q] = 1'b1;
    end
  end

  assign RESULT     = result_q;
  assign ERR        = err_q;
  assign BUSY       = (state_q != S_IDLE);
  assign MULT_START = (state_q == S_LAUNCH);
  assign MULT_A     = a_q;
  assign MULT_B     = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: multiplier stub, transaction-level reference model, directed and random traffic.
module tb_mult_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TO = 64;

  logic           CLOCK = 1'b0;
  logic           RESET = 1'b0;
  logic [N-1:0]   REQ = '0;
  logic [N*W-1:0] A_IN = '0;
  logic [N*W-1:0] B_IN = '0;
  logic [N-1:0]   GNT, DONE;
  logic [2*W-1:0] RESULT;
  logic           ERR, BUSY, MULT_START;
  logic [W-1:0]   MULT_A, MULT_B;
  logic [2*W-1:0] MULT_S = '0;
  logic           MULT_END = 1'b0;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;

  int stub_lat = 0;
  int stub_hold = 0;
  bit stub_hung = 1'b0;
  bit stub_force = 1'b0;

  mult_arbiter #(.tamano(W), .N_REQ(N), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN),
    .GNT(GNT), .DONE(DONE), .RESULT(RESULT), .ERR(ERR), .BUSY(BUSY),
    .MULT_START(MULT_START), .MULT_A(MULT_A), .MULT_B(MULT_B),
    .MULT_S(MULT_S), .MULT_END(MULT_END)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier stub: after START, END stays high for 'hold' stale cycles, is low for lat+1
  // cycles, then rises with the product (or 0x1234 when forced). Hung mode pins END low.
  initial begin : stub
    int k, lat, hold;
    bit run;
    logic [W-1:0] sa, sb;
    logic nend;
    logic [2*W-1:0] ns;
    k = 0; lat = 0; hold = 0; run = 1'b0; sa = '0; sb = '0; nend = 1'b0; ns = '0;
    forever begin
      @(negedge CLOCK);
      if (!RESET) run = 1'b0;
      else if (MULT_START) begin
        run = 1'b1; k = 0; sa = MULT_A; sb = MULT_B; lat = stub_lat; hold = stub_hold;
      end
      if (run) begin
        k++;
        if (k <= hold) nend = 1'b1;
        else if (k <= hold + lat + 1) nend = 1'b0;
        else begin
          nend = 1'b1;
          ns   = stub_force ? 16'h1234 : sa * sb;
          run  = 1'b0;
        end
      end
      @(posedge CLOCK);
      #1;
      MULT_END = stub_hung ? 1'b0 : nend;
      MULT_S   = ns;
    end
  end

  // Reference model: one operation record (winner, operands, age since grant) plus the
  // rotating priority start. Outputs are predicted for the current cycle, then the record advances.
  bit           m_active = 1'b0, m_resp = 1'b0, m_err = 1'b0, m_seen = 1'b0;
  int           m_age = 0, m_ptr = 0, m_win = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [2*W-1:0] m_res = '0;

  initial begin : compare
    logic [N-1:0] e_gnt, e_done;
    int w;
    forever begin
      @(negedge CLOCK);
      if (!RESET) begin
        m_active = 0; m_resp = 0; m_err = 0; m_seen = 0;
        m_age = 0; m_ptr = 0; m_win = 0; m_a = '0; m_b = '0; m_res = '0;
      end
      w = -1;
      if (RESET && !m_active)
        for (int k = 0; k < N; k++)
          if (w < 0 && REQ[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      e_gnt = '0;
      if (w >= 0) e_gnt[w] = 1'b1;
      e_done = '0;
      if (m_resp) e_done[m_win] = 1'b1;
      chk("GNT", 32'(GNT), 32'(e_gnt));
      chk("DONE", 32'(DONE), 32'(e_done));
      chk("BUSY", 32'(BUSY), 32'(m_active));
      chk("MULT_START", 32'(MULT_START), 32'(m_active && !m_resp && m_age == 1));
      chk("ERR", 32'(ERR), 32'(m_resp && m_err));
      chk("RESULT", 32'(RESULT), 32'(m_res));
      chk("MULT_A", 32'(MULT_A), 32'(m_a));
      chk("MULT_B", 32'(MULT_B), 32'(m_b));
      if (DONE != '0) n_done++;
      if (RESET) begin
        if (!m_active) begin
          if (w >= 0) begin
            m_active = 1; m_resp = 0; m_win = w; m_age = 1; m_seen = 0;
            m_a = A_IN[w*W +: W]; m_b = B_IN[w*W +: W];
          end
        end else if (m_resp) begin
          m_active = 0; m_resp = 0; m_err = 0; m_ptr = (m_win + 1) % N;
        end else begin
          if (m_age >= 2) begin
            if (MULT_END && m_seen) begin
              m_res = stub_force ? 16'h1234 : m_a * m_b; m_err = 0; m_resp = 1;
            end else if (m_age - 2 == TO - 1) begin
              m_res = '0; m_err = 1; m_resp = 1;
            end
            if (!MULT_END) m_seen = 1;
          end
          m_age++;
        end
      end
    end
  end

  task automatic set_op(input int i, input int a, input int b);
    A_IN[i*W +: W] = W'(a);
    B_IN[i*W +: W] = W'(b);
  endtask

  // Waits (bounded) for the next DONE, recording grant, launch and completion details.
  task automatic watch(input bit drop, output logic [N-1:0] g, output int gc, output int sc,
                       output logic [W-1:0] sa, output logic [W-1:0] sb,
                       output logic [2*W-1:0] r, output logic e, output int dc,
                       output logic [N-1:0] d);
    g = '0; gc = -1; sc = -1; sa = '0; sb = '0; r = '0; e = 1'b0; dc = -1; d = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK);
      if (GNT != '0 && gc < 0) begin g = GNT; gc = cyc; end
      if (MULT_START && sc < 0) begin sc = cyc; sa = MULT_A; sb = MULT_B; end
      if (DONE != '0) begin d = DONE; r = RESULT; e = ERR; dc = cyc; break; end
      if (drop && gc == cyc) begin
        @(posedge CLOCK);
        #1;
        REQ = '0;
      end
    end
    if (dc < 0) chk("done_within_budget", 32'(dc), 32'(0));
  endtask

  initial begin : main
    logic [N-1:0] g, d;
    int gc, sc, dc, n0;
    bit got;
    logic [W-1:0] sa, sb;
    logic [2*W-1:0] r;
    logic e;
    int exp_g[5] = '{1, 2, 4, 8, 1};
    int exp_r[5] = '{6, 12, 20, 30, 6};

    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_BUSY", 32'(BUSY), 0);
    chk("rst_RESULT", 32'(RESULT), 0);
    chk("rst_MULT_START", 32'(MULT_START), 0);
    @(posedge CLOCK);
    #2 RESET = 1'b1;

    // Round-robin with all four requesting
    @(posedge CLOCK);
    #1;
    for (int i = 0; i < N; i++) set_op(i, i + 2, i + 3);
    stub_lat = 1;
    REQ = '1;
    for (int n = 0; n < 5; n++) begin
      watch(1'b0, g, gc, sc, sa, sb, r, e, dc, d);
      chk("rr_gnt", 32'(g), 32'(exp_g[n]));
      chk("rr_done", 32'(d), 32'(exp_g[n]));
      chk("rr_result", 32'(r), 32'(exp_r[n]));
    end
    @(posedge CLOCK);
    #1 REQ = '0;

    // Single request
    @(posedge CLOCK);
    #1;
    set_op(0, 13, 11); stub_lat = 2; REQ = 4'b0001;
    watch(1'b1, g, gc, sc, sa, sb, r, e, dc, d);
    chk("t1_gnt", 32'(g), 1);
    chk("t1_start_delay", 32'(sc - gc), 1);
    chk("t1_mult_a", 32'(sa), 13);
    chk("t1_mult_b", 32'(sb), 11);
    chk("t1_done", 32'(d), 1);
    chk("t1_result", 32'(r), 143);
    chk("t1_err", 32'(e), 0);
    @(negedge CLOCK);
    chk("t1_busy_after_done", 32'(BUSY), 0);

    // Boundary operands
    @(posedge CLOCK);
    #1;
    set_op(2, 255, 255); REQ = 4'b0100;
    watch(1'b1, g, gc, sc, sa, sb, r, e, dc, d);
    chk("t3_max_result", 32'(r), 32'hFE01);
    chk("t3_max_err", 32'(e), 0);
    @(posedge CLOCK);
    #1;
    set_op(3, 0, 200); REQ = 4'b1000;
    watch(1'b1, g, gc, sc, sa, sb, r, e, dc, d);
    chk("t3_zero_result", 32'(r), 0);
    chk("t3_zero_err", 32'(e), 0);

    // Stale END level
    @(posedge CLOCK);
    #1;
    stub_force = 1'b1; stub_hold = 0; stub_lat = 1;
    set_op(1, 3, 5); REQ = 4'b0010;
    watch(1'b1, g, gc, sc, sa, sb, r, e, dc, d);
    chk("t4_result", 32'(r), 32'h1234);
    chk("t4_latency", 32'(dc - gc), 5);
    @(posedge CLOCK);
    #1;
    stub_hold = 2; stub_lat = 0; REQ = 4'b0010;
    watch(1'b1, g, gc, sc, sa, sb, r, e, dc, d);
    chk("t4_held_result", 32'(r), 32'h1234);
    chk("t4_held_latency", 32'(dc - gc), 6);
    stub_force = 1'b0; stub_hold = 0;

    // Timeout
    @(posedge CLOCK);
    #1;
    stub_hung = 1'b1; set_op(3, 9, 9); REQ = 4'b1000;
    watch(1'b1, g, gc, sc, sa, sb, r, e, dc, d);
    chk("t5_done", 32'(d), 32'h8);
    chk("t5_err", 32'(e), 1);
    chk("t5_result", 32'(r), 0);
    chk("t5_latency", 32'(dc - gc), 66);
    @(posedge CLOCK);
    #1;
    stub_hung = 1'b0; stub_lat = 2; set_op(0, 7, 9); REQ = 4'b0001;
    watch(1'b1, g, gc, sc, sa, sb, r, e, dc, d);
    chk("t5_next_result", 32'(r), 63);
    chk("t5_next_err", 32'(e), 0);

    // Reset mid-operation
    @(posedge CLOCK);
    #1;
    set_op(2, 10, 12); REQ = 4'b0100;
    watch(1'b1, g, gc, sc, sa, sb, r, e, dc, d);
    chk("t6_pre_result", 32'(r), 120);
    @(posedge CLOCK);
    #1;
    stub_lat = 5; set_op(1, 21, 3); REQ = 4'b0010;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLOCK);
      if (GNT != '0) got = 1'b1;
    end
    chk("t6_gnt_seen", 32'(got), 1);
    @(posedge CLOCK);
    #1 REQ = '0;
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1;
    chk("t6_busy_before_reset", 32'(BUSY), 1);
    #2 RESET = 1'b0;
    #1;
    chk("t6_BUSY", 32'(BUSY), 0);
    chk("t6_MULT_START", 32'(MULT_START), 0);
    chk("t6_MULT_A", 32'(MULT_A), 0);
    chk("t6_MULT_B", 32'(MULT_B), 0);
    chk("t6_RESULT", 32'(RESULT), 0);
    chk("t6_DONE", 32'(DONE), 0);
    chk("t6_ERR", 32'(ERR), 0);
    @(posedge CLOCK);
    #1;
    set_op(2, 4, 4); set_op(3, 5, 5); REQ = 4'b1100;
    @(posedge CLOCK);
    #2 RESET = 1'b1;
    watch(1'b1, g, gc, sc, sa, sb, r, e, dc, d);
    chk("t6_gnt_after_reset", 32'(g), 32'h4);
    chk("t6_done_after_reset", 32'(d), 32'h4);
    chk("t6_result_after_reset", 32'(r), 16);

    // Random traffic against the model
    n0 = n_done;
    for (int c = 0; c < 4000; c++) begin
      @(posedge CLOCK);
      #1;
      stub_lat  = $urandom_range(0, 5);
      stub_hold = $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0) begin
        REQ  = N'($urandom);
        A_IN = $urandom;
        B_IN = $urandom;
      end
    end
    chk("rand_progress", 32'(n_done - n0 >= 150), 1);
    @(posedge CLOCK);
    #1 REQ = '0;
    repeat (20) @(posedge CLOCK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
